// File: rtl/sr_register_bank.sv
// rtl/sr_register_bank.sv - multi-bit set/reset flag register with conflict policy and counter
module sr_register_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
  parameter int               CNT_W         = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic             CLR_CNT,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] CHANGED,
  output logic             CONFLICT,
  output logic [CONFLICT_MODE >= 0 ? CNT_W-1 : CNT_W-1:0] CONFLICT_CNT
);

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_RESET  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;
  localparam logic [1:0] MODE        = CONFLICT_MODE[1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic             conflict_eff;

  // Next-state selection: LOAD beats S/R, and S/R only act while EN is high
  always_comb begin
    q_next       = Q;
    conflict_eff = 1'b0;
    if (LOAD) begin
      q_next = D;
    end else if (EN) begin
      conflict_eff = |(S & R);
      for (int i = 0; i < WIDTH; i++) begin
        case ({S[i], R[i]})
          2'b10:   q_next[i] = 1'b1;
          2'b01:   q_next[i] = 1'b0;
          2'b11: begin
            case (MODE)
              MODE_SET:    q_next[i] = 1'b1;
              MODE_RESET:  q_next[i] = 1'b0;
              MODE_TOGGLE: q_next[i] = ~Q[i];
              default:     q_next[i] = Q[i];
            endcase
          end
          default: q_next[i] = Q[i];
        endcase
      end
    end
  end

  // State, change flags, conflict pulse and saturating conflict counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q            <= RESET_VALUE;
      CHANGED      <= '0;
      CONFLICT     <= 1'b0;
      CONFLICT_CNT <= '0;
    end else begin
      Q        <= q_next;
      CHANGED  <= q_next ^ Q;
      CONFLICT <= conflict_eff;
      if (CLR_CNT) begin
        CONFLICT_CNT <= '0;
      end else if (conflict_eff && (CONFLICT_CNT != CNT_MAX)) begin
        CONFLICT_CNT <= CONFLICT_CNT + CNT_W'(1);
      end
    end
  end

  assign Qn = ~Q;

endmodule

// File: doc/sr_register_bank.md
# sr_register_bank

Parametrised bank of WIDTH independent set/reset storage bits with a selectable S/R-conflict policy, parallel load, clock enable, per-bit change flags and a saturating conflict-event counter. Generalises the single-bit SR flip-flop into a multi-bit status/flag register. Typical uses are interrupt-pending, sticky-error and handshake flags driven by several set and clear sources. Single clock domain, fully synchronous.

## Interface
- WIDTH, 8, number of storage bits (>= 1)
- CONFLICT_MODE, 0, per-bit behaviour when S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle; other values are illegal
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q by RST
- CNT_W, 8, width of the conflict counter (>= 1)

- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- EN  input  1  enables S/R updates; LOAD does not depend on EN
- LOAD  input  1  parallel load of D into Q; overrides S/R
- D  input  WIDTH  parallel load data
- S  input  WIDTH  per-bit set request
- R  input  WIDTH  per-bit reset request
- CLR_CNT  input  1  synchronous clear of CONFLICT_CNT
- Q  output  WIDTH  registered state
- Qn  output  WIDTH  combinational ~Q
- CHANGED  output  WIDTH  registered; bit i = 1 for one cycle after the edge at which Q[i] changed
- CONFLICT  output  1  registered; 1 for one cycle after an edge at which any bit saw an effective S=R=1
- CONFLICT_CNT  output  CNT_W  saturating count of conflict cycles

## Operation
- Priority at each rising CLK edge: RST > LOAD > (EN and S/R) > hold.
- RST=1: Q <= RESET_VALUE; CHANGED <= 0; CONFLICT <= 0; CONFLICT_CNT <= 0. All other inputs are ignored.
- LOAD=1 (RST=0): Q <= D. S, R and EN are ignored. No conflict is recorded.
- EN=1, LOAD=0, per bit i:
  - S=1, R=0 sets the bit to 1.
  - S=0, R=1 clears the bit to 0.
  - S=0, R=0 holds the bit.
  - S=1, R=1 follows CONFLICT_MODE (hold / 1 / 0 / ~Q[i]).
- EN=0, LOAD=0: Q holds. S and R are ignored. No conflict is recorded.
- CHANGED <= Q_next ^ Q_current on every non-reset edge. This includes changes caused by LOAD.
- Effective conflict: EN=1, LOAD=0, RST=0, and (S & R) != 0. One event is recorded per cycle regardless of how many bits conflict.
- On an effective conflict, CONFLICT <= 1; otherwise CONFLICT <= 0.
- CONFLICT_CNT update, in priority order:
  - CLR_CNT=1: the counter becomes 0. If a conflict occurs in the same cycle, it is not counted; CONFLICT still pulses.
  - Effective conflict with count < 2^CNT_W-1: count increments by 1.
  - Count at 2^CNT_W-1: the counter stays saturated (no wrap).
- Conflict detection and counting are independent of CONFLICT_MODE, including mode 0, where Q does not change.
- Qn is combinational from Q and is always exactly ~Q, including during and after reset.

## Timing
- Q, CHANGED, CONFLICT and CONFLICT_CNT all update on the same edge that samples the inputs: one cycle of latency from input to output.
- No combinational path exists from any input to any output except Q -> Qn.
- Reset values:
  - Q = RESET_VALUE
  - Qn = ~RESET_VALUE
  - CHANGED = 0
  - CONFLICT = 0
  - CONFLICT_CNT = 0
- RST asserted mid-operation (during a LOAD, a conflict, or a count at saturation) wins on that edge. Normal operation resumes on the first edge with RST=0.
- Toggle mode with S=R=1 held for N enabled cycles flips the bit on every edge. CHANGED[i] then stays 1 for those N cycles, and the counter increments N times (subject to saturation).

## Test plan
- Reset, WIDTH=8, RESET_VALUE=8'hA5: assert RST for 2 cycles with random S/R/LOAD -> Q=8'hA5, Qn=8'h5A, CHANGED=0, CONFLICT=0, CONFLICT_CNT=0.
- Basic S/R, starting from Q=8'h00 with EN=1: S=8'h0F, R=0 -> Q=8'h0F, CHANGED=8'h0F. Next S=0, R=8'h03 -> Q=8'h0C, CHANGED=8'h03. Next S=R=0 -> Q holds, CHANGED=0.
- Conflict modes, starting from Q=8'h0C, S=R=8'hFF, EN=1 for one cycle:
  - mode 0 -> Q=8'h0C
  - mode 1 -> Q=8'hFF
  - mode 2 -> Q=8'h00
  - mode 3 -> Q=8'hF3
  - In every mode: CONFLICT=1 for one cycle, CONFLICT_CNT=1.
- LOAD and EN precedence: LOAD=1, D=8'h3C, EN=0, S=R=8'hFF -> Q=8'h3C, CONFLICT=0, counter unchanged. Then EN=0, LOAD=0, S=8'hFF -> Q stays 8'h3C.
- Counter saturation, CNT_W=2: 5 consecutive conflict cycles -> CONFLICT_CNT reads 1, 2, 3, 3, 3. Then CLR_CNT=1 together with a conflict -> CONFLICT_CNT=0 and CONFLICT=1.
- Reset mid-toggle, mode 3: S=R=8'h01 for 3 cycles gives Q[0] = 1, 0, 1. Assert RST on the 4th cycle -> Q=RESET_VALUE and CONFLICT_CNT=0. Release RST with S=R=0 -> state holds.
